// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates a 32-bit fetch port and a 1/2/4-byte
// data port onto an 8-bit synchronous RAM with one cycle of read latency.
module mem_ctrl #(
    parameter int ADDR_USED = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_data_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_ack_o,
    output logic [31:0] mem_rdata_o,
    output logic        busy_o,
    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [31:0] ADDR_MASK =
        (ADDR_USED >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ADDR_USED) - 32'd1);

    state_t      state;
    logic        is_fetch;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;
    logic [2:0]  len_q;
    logic [2:0]  step;
    logic        wr_q;

    logic [31:0] next_a;
    logic [1:0]  next_idx;
    logic [1:0]  cap_idx;
    logic [31:0] data_merged;

    function automatic logic [2:0] byte_count(input logic [1:0] len);
        case (len)
            2'd0:    byte_count = 3'd1;
            2'd1:    byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    assign next_a   = (addr_q + 32'(step) + 32'd1) & ADDR_MASK;
    assign next_idx = step[1:0] + 2'd1;
    assign cap_idx  = step[1:0] - 2'd1;

    // The strobe is gated by rdy so a stalled write cycle never reaches the RAM.
    assign ram_wr_o = wr_q & rdy;

    // In RD, step counts cycles since entry; the byte addressed in step s-1 arrives in step s.
    always_comb begin
        data_merged = data_q;
        if (step != 3'd0)
            data_merged[8*cap_idx +: 8] = ram_din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_fetch    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            len_q       <= '0;
            step        <= '0;
            wr_q        <= 1'b0;
            if_ack_o    <= 1'b0;
            if_data_o   <= '0;
            mem_ack_o   <= 1'b0;
            mem_rdata_o <= '0;
            busy_o      <= 1'b0;
            ram_dout_o  <= '0;
            ram_a_o     <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    step   <= '0;
                    data_q <= '0;
                    if (mem_req_i) begin
                        is_fetch <= 1'b0;
                        addr_q   <= mem_addr_i;
                        wdata_q  <= mem_wdata_i;
                        len_q    <= byte_count(mem_len_i);
                        ram_a_o  <= mem_addr_i & ADDR_MASK;
                        busy_o   <= 1'b1;
                        if (mem_we_i) begin
                            state      <= WR;
                            ram_dout_o <= mem_wdata_i[7:0];
                            wr_q       <= 1'b1;
                        end else begin
                            state <= RD;
                        end
                    end else if (if_req_i) begin
                        is_fetch <= 1'b1;
                        addr_q   <= if_addr_i;
                        len_q    <= 3'd4;
                        ram_a_o  <= if_addr_i & ADDR_MASK;
                        busy_o   <= 1'b1;
                        state    <= RD;
                    end
                end
                RD: begin
                    data_q <= data_merged;
                    if (step == len_q) begin
                        state   <= DONE;
                        ram_a_o <= '0;
                        if (is_fetch) begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= data_merged;
                        end else begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= data_merged;
                        end
                    end else begin
                        step    <= step + 3'd1;
                        ram_a_o <= ((step + 3'd1) < len_q) ? next_a : 32'd0;
                    end
                end
                WR: begin
                    if ((step + 3'd1) < len_q) begin
                        step       <= step + 3'd1;
                        ram_a_o    <= next_a;
                        ram_dout_o <= wdata_q[8*next_idx +: 8];
                    end else begin
                        state      <= DONE;
                        ram_a_o    <= '0;
                        ram_dout_o <= '0;
                        wr_q       <= 1'b0;
                        mem_ack_o  <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    if_ack_o    <= 1'b0;
                    if_data_o   <= '0;
                    mem_ack_o   <= 1'b0;
                    mem_rdata_o <= '0;
                    busy_o      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
